// File: rtl/eth_mac_pkg.sv
// Shared Ethernet MAC definitions: RGMII speed codes, MDIO opcodes and the
// PHY speed-control state encoding.
package eth_mac_pkg;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10,
    SPEED_RSVD = 2'b11
  } speed_t;

  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT_RSP,
    ST_UPDATE,
    ST_HOLD
  } speed_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phy_speed_ctrl.sv
// Polls the PHY status register over MDIO and drives RGMII speed, link state
// and a MAC hold window whenever speed or link changes.
module phy_speed_ctrl
  import eth_mac_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR       = 5'd1,
  parameter logic [4:0]  STATUS_REG     = 5'h11,
  parameter int unsigned SPEED_LSB      = 14,
  parameter int unsigned LINK_BIT       = 10,
  parameter int unsigned POLL_CYCLES    = 125000,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned HOLD_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        cmd_valid,
  output logic [1:0]  cmd_opcode,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_data,
  output logic        rsp_ready,
  output logic [1:0]  speed,
  output logic        link_up,
  output logic        mac_hold,
  output logic        speed_change,
  output logic        timeout_err,
  output logic        code_err
);

  localparam int unsigned CNT_MAX = max3(POLL_CYCLES, TIMEOUT_CYCLES, HOLD_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] POLL_LOAD    = CNT_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  speed_state_t     state;
  logic [CNT_W-1:0] cnt;
  speed_t           speed_q;
  logic [15:0]      rsp_q;
  logic             link_bit;
  speed_t           code;
  logic             unused_rsp;

  assign cmd_opcode   = MDIO_OP_READ;
  assign cmd_phy_addr = PHY_ADDR;
  assign cmd_reg_addr = STATUS_REG;
  assign cmd_data     = '0;
  assign speed        = speed_q;

  assign link_bit   = rsp_q[LINK_BIT];
  assign code       = speed_t'(rsp_q[SPEED_LSB +: 2]);
  assign unused_rsp = ^rsp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      speed_q      <= SPEED_1000;
      link_up      <= 1'b0;
      mac_hold     <= 1'b0;
      cmd_valid    <= 1'b0;
      rsp_ready    <= 1'b0;
      speed_change <= 1'b0;
      timeout_err  <= 1'b0;
      code_err     <= 1'b0;
      rsp_q        <= '0;
    end else begin
      speed_change <= 1'b0;
      timeout_err  <= 1'b0;
      code_err     <= 1'b0;
      unique case (state)
        // cnt==0 marks the first idle cycle; reloading there and leaving at 1
        // gives exactly POLL_CYCLES idle cycles while the counter stays down-only.
        ST_IDLE: begin
          if (!enable) begin
            cnt <= '0;
          end else if (cnt == '0) begin
            cnt <= POLL_LOAD;
          end else if (cnt == CNT_ONE) begin
            cnt       <= '0;
            cmd_valid <= 1'b1;
            state     <= ST_CMD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CMD: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            rsp_ready <= 1'b1;
            cnt       <= TIMEOUT_LOAD;
            state     <= ST_WAIT_RSP;
          end
        end
        // A response in the final timeout cycle wins over the timeout.
        ST_WAIT_RSP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_q     <= rsp_data;
            rsp_ready <= 1'b0;
            cnt       <= '0;
            state     <= ST_UPDATE;
          end else if (cnt == '0) begin
            rsp_ready   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_UPDATE: begin
          state <= ST_IDLE;
          if (!link_bit) begin
            link_up <= 1'b0;
            if (link_up) begin
              mac_hold <= 1'b1;
              cnt      <= HOLD_LOAD;
              state    <= ST_HOLD;
            end
          end else if (code == SPEED_RSVD) begin
            code_err <= 1'b1;
          end else begin
            speed_q <= code;
            link_up <= 1'b1;
            if ((code != speed_q) || !link_up) begin
              speed_change <= 1'b1;
              mac_hold     <= 1'b1;
              cnt          <= HOLD_LOAD;
              state        <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            mac_hold <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_speed_ctrl.sv
// Scoreboard bench for phy_speed_ctrl: a PHY responder model pushes expected
// speed/link/event outcomes per read and checks them once the update settles.
module tb_phy_speed_ctrl;

  localparam int POLL = 8;
  localparam int TMO  = 64;
  localparam int HOLD = 16;
  localparam int WIN  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_opcode;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_data;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_data = '0;
  logic        rsp_ready;
  logic [1:0]  speed;
  logic        link_up;
  logic        mac_hold;
  logic        speed_change;
  logic        timeout_err;
  logic        code_err;

  always #5 clk = ~clk;

  phy_speed_ctrl #(
    .PHY_ADDR(5'd1), .STATUS_REG(5'h11), .SPEED_LSB(14), .LINK_BIT(10),
    .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_phy_addr(cmd_phy_addr),
    .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .speed(speed), .link_up(link_up), .mac_hold(mac_hold),
    .speed_change(speed_change), .timeout_err(timeout_err), .code_err(code_err)
  );

  typedef struct {
    logic [1:0] speed;
    logic       link;
    int         changes;
    int         code_errs;
    int         holds;
    int         timeouts;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_speed = 2'b10;
  logic       m_link  = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic clear_obs(output exp_t o);
    o.speed = speed; o.link = link_up;
    o.changes = 0; o.code_errs = 0; o.holds = 0; o.timeouts = 0;
  endtask

  task automatic sample(inout exp_t o);
    o.changes   += int'(speed_change);
    o.code_errs += int'(code_err);
    o.holds     += int'(mac_hold);
    o.timeouts  += int'(timeout_err);
    o.speed = speed;
    o.link  = link_up;
  endtask

  task automatic push_expect(input logic [15:0] r, input bit is_timeout);
    exp_t e;
    e.changes = 0; e.code_errs = 0; e.holds = 0; e.timeouts = 0;
    if (is_timeout) begin
      e.timeouts = 1;
    end else if (!r[10]) begin
      e.holds = m_link ? HOLD : 0;
      m_link = 1'b0;
    end else if (r[15:14] == 2'b11) begin
      e.code_errs = 1;
    end else begin
      if ((r[15:14] != m_speed) || !m_link) begin
        e.changes = 1;
        e.holds   = HOLD;
      end
      m_speed = r[15:14];
      m_link  = 1'b1;
    end
    e.speed = m_speed;
    e.link  = m_link;
    sb.push_back(e);
  endtask

  task automatic score(input string name, input exp_t o);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, required one entry", name);
      return;
    end
    e = sb.pop_front();
    checks++; if (o.speed !== e.speed) begin errors++;
      $display("FAIL %s speed: got %b required %b", name, o.speed, e.speed); end
    checks++; if (o.link !== e.link) begin errors++;
      $display("FAIL %s link_up: got %b required %b", name, o.link, e.link); end
    checks++; if (o.changes != e.changes) begin errors++;
      $display("FAIL %s speed_change pulses: got %0d required %0d", name, o.changes, e.changes); end
    checks++; if (o.code_errs != e.code_errs) begin errors++;
      $display("FAIL %s code_err pulses: got %0d required %0d", name, o.code_errs, e.code_errs); end
    checks++; if (o.holds != e.holds) begin errors++;
      $display("FAIL %s mac_hold cycles: got %0d required %0d", name, o.holds, e.holds); end
    checks++; if (o.timeouts != e.timeouts) begin errors++;
      $display("FAIL %s timeout_err pulses: got %0d required %0d", name, o.timeouts, e.timeouts); end
  endtask

  task automatic wait_cmd(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cmd_valid: got 0 required 1 within 200 cycles", name);
    end
  endtask

  task automatic check_fields(input string name);
    checks++;
    if ({cmd_opcode, cmd_phy_addr, cmd_reg_addr, cmd_data} !== {2'b10, 5'd1, 5'h11, 16'h0000}) begin
      errors++;
      $display("FAIL %s cmd fields: got op=%b phy=%h reg=%h data=%h required op=10 phy=01 reg=11 data=0000",
               name, cmd_opcode, cmd_phy_addr, cmd_reg_addr, cmd_data);
    end
  endtask

  task automatic handshake(input string name);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: got cmd_valid=%b rsp_ready=%b required 0/1", name, cmd_valid, rsp_ready);
    end
  endtask

  task automatic transact(input string name, input logic [15:0] r, input int delay,
                          input int stall);
    bit ok;
    int bad;
    exp_t o;
    logic [1:0] old_speed;
    wait_cmd(name, ok);
    if (!ok) return;
    check_fields(name);
    if (stall > 0) begin
      enable = 1'b0;
      bad = 0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (cmd_valid !== 1'b1 || {cmd_opcode, cmd_phy_addr, cmd_reg_addr, cmd_data}
            !== {2'b10, 5'd1, 5'h11, 16'h0000}) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s stall stability: got %0d unstable cycles required 0", name, bad);
      end
    end
    handshake(name);
    old_speed = m_speed;
    push_expect(r, 1'b0);
    repeat (delay) @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data  = r;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = '0;
    clear_obs(o);
    sample(o);
    checks++;
    if (speed !== old_speed) begin
      errors++;
      $display("FAIL %s update latency: got speed %b before update edge required %b", name, speed, old_speed);
    end
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      sample(o);
    end
    score(name, o);
  endtask

  task automatic test_reset();
    int k;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_valid, rsp_ready, speed, link_up, mac_hold, speed_change, timeout_err, code_err}
        !== 9'b0_0_10_0_0_000) begin
      errors++;
      $display("FAIL reset outputs: got cv=%b rr=%b spd=%b link=%b hold=%b pulses=%b%b%b required 0 0 10 0 0 000",
               cmd_valid, rsp_ready, speed, link_up, mac_hold, speed_change, timeout_err, code_err);
    end
    rst_n = 1'b1;
    k = 0;
    while (cmd_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != POLL) begin
      errors++;
      $display("FAIL reset poll delay: got %0d cycles required %0d", k, POLL);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    exp_t o;
    wait_cmd("timeout", ok);
    if (!ok) return;
    handshake("timeout");
    push_expect(16'h0000, 1'b1);
    clear_obs(o);
    k = 0;
    for (int i = 1; i <= TMO + 20; i++) begin
      @(negedge clk);
      sample(o);
      if (timeout_err === 1'b1 && k == 0) k = i;
    end
    checks++;
    if (k != TMO) begin
      errors++;
      $display("FAIL timeout latency: got %0d cycles required %0d", k, TMO);
    end
    score("timeout", o);
  endtask

  task automatic test_enable_low();
    int k;
    int seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen += int'(cmd_valid);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL enable_low cmd_valid: got %0d active cycles required 0", seen);
    end
    enable = 1'b1;
    k = 0;
    while (cmd_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != POLL) begin
      errors++;
      $display("FAIL enable_low poll delay: got %0d cycles required %0d", k, POLL);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    int ev;
    wait_cmd("reset_mid", ok);
    if (!ok) return;
    handshake("reset_mid");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, rsp_ready, speed, link_up, mac_hold} !== 6'b0_0_10_0_0) begin
      errors++;
      $display("FAIL reset_mid async: got cv=%b rr=%b spd=%b link=%b hold=%b required 0 0 10 0 0",
               cmd_valid, rsp_ready, speed, link_up, mac_hold);
    end
    m_speed = 2'b10;
    m_link  = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 16'h4400;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = '0;
    k  = 1;
    ev = 0;
    while (cmd_valid !== 1'b1 && k < 200) begin
      ev += int'(speed_change) + int'(code_err) + int'(timeout_err) + int'(mac_hold)
            + int'(speed !== 2'b10) + int'(link_up !== 1'b0);
      @(negedge clk);
      k++;
    end
    checks++;
    if (ev != 0) begin
      errors++;
      $display("FAIL reset_mid late rsp: got %0d state/event changes required 0", ev);
    end
    checks++;
    if (k != POLL) begin
      errors++;
      $display("FAIL reset_mid poll delay: got %0d cycles required %0d", k, POLL);
    end
  endtask

  initial begin
    test_reset();
    transact("link_1000", 16'h8400, 2, 0);
    transact("to_100", 16'h4400, 0, 0);
    transact("repeat_100", 16'h4400, 1, 0);
    transact("link_down", 16'h0000, 0, 0);
    transact("link_down_again", 16'h0000, 0, 0);
    transact("code_err", 16'hC400, 0, 0);
    test_timeout();
    transact("rsp_at_timeout", 16'h8400, TMO - 1, 0);
    transact("stall_enable_low", 16'h4400, 3, 50);
    test_enable_low();
    test_reset_mid();
    transact("after_reset", 16'h8400, 0, 0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/phy_speed_ctrl.md
PHY_SPEED_CTRL -- requirements
Module: phy_speed_ctrl

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: MDIO address of the PHY.
REQ-002 SHALL have parameter STATUS_REG, default 5'h11: PHY-specific status register address.
REQ-003 SHALL have parameter SPEED_LSB, default 14: bit position of the 2-bit speed field in the status word.
REQ-004 SHALL have parameter LINK_BIT, default 10: bit position of the real-time link flag in the status word.
REQ-005 SHALL have parameter POLL_CYCLES, default 125000: clk cycles between status reads.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum wait for an MDIO response.
REQ-007 SHALL have parameter HOLD_CYCLES, default 16: MAC hold length after a speed or link change.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic is synchronous to it.
REQ-009 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port enable, input, 1 bit: polling is permitted while high.
REQ-011 SHALL have MDIO command channel outputs cmd_valid (1), cmd_opcode (2), cmd_phy_addr (5), cmd_reg_addr (5), cmd_data (16), plus input cmd_ready (1).
REQ-012 SHALL have MDIO response channel inputs rsp_valid (1) and rsp_data (16), plus output rsp_ready (1).
REQ-013 SHALL have port speed, output, 2 bits: 00 = 10M, 01 = 100M, 10 = 1000M; drives the RGMII interface speed control.
REQ-014 SHALL have port link_up, output, 1 bit: link status from the last valid read.
REQ-015 SHALL have port mac_hold, output, 1 bit: holds the MAC/RGMII datapath in reset while high.
REQ-016 SHALL have ports speed_change, timeout_err and code_err, outputs, 1 bit each: single-cycle event pulses.

Function
REQ-017 SHALL implement FSM states IDLE, CMD, WAIT_RSP, UPDATE, HOLD.
REQ-018 IDLE SHALL count POLL_CYCLES with a wait counter sized by $clog2, then go to CMD if enable=1; otherwise it SHALL stay in IDLE with the counter held at 0.
REQ-019 CMD SHALL hold cmd_valid=1 with stable fields: opcode=2'b10 (read), PHY_ADDR, STATUS_REG, data=0.
REQ-020 CMD SHALL move to WAIT_RSP in the cycle after cmd_valid&&cmd_ready.
REQ-021 WAIT_RSP SHALL hold rsp_ready=1, capture rsp_data on rsp_valid&&rsp_ready, then go to UPDATE.
REQ-022 If no response arrives within TIMEOUT_CYCLES, WAIT_RSP SHALL pulse timeout_err and return to IDLE with speed and link_up unchanged.
REQ-023 A response arriving in the same cycle the timeout expires SHALL be accepted; no timeout_err SHALL be raised.
REQ-024 UPDATE with link bit=0: link_up SHALL clear, speed SHALL be unchanged, and HOLD SHALL be entered only if link_up was 1; otherwise go to IDLE.
REQ-025 UPDATE with link bit=1 and speed code 11 (reserved): code_err SHALL pulse, and speed and link_up SHALL be unchanged; go to IDLE.
REQ-026 UPDATE with link bit=1 and a valid code: speed and link_up SHALL load in the same cycle.
REQ-027 In that case, if the code differs from speed or link_up was 0, speed_change SHALL pulse and HOLD SHALL be entered; otherwise go to IDLE.
REQ-028 HOLD SHALL assert mac_hold for exactly HOLD_CYCLES cycles, then return to IDLE.
REQ-029 mac_hold SHALL be a registered output, high only in HOLD.
REQ-030 enable deasserted mid-transaction SHALL NOT abort CMD or WAIT_RSP; it takes effect only in IDLE.
REQ-031 Command-to-update latency SHALL be response cycle + 1.
REQ-032 speed SHALL change only on the UPDATE edge.

Reset
REQ-033 While rst_n=0, SHALL force: state=IDLE, counters=0, speed=2'b10, link_up=0, mac_hold=0, cmd_valid=0, rsp_ready=0, and all pulses=0.
REQ-034 Reset asserted mid-transaction SHALL drop cmd_valid immediately; after reset, the next command SHALL start only after a full POLL_CYCLES.

Structure
REQ-035 Speed encodings, MDIO opcodes and FSM state encodings SHALL live in a shared package (eth_mac_pkg) used by the RGMII interface and the MDIO master.
REQ-036 There SHALL be no sub-module; a single FSM with one shared down-counter for poll, timeout and hold.

Verification
REQ-037 POLL_CYCLES=8, enable=1, response 16'h8400 (link=1, code 10): one read issued with phy=1, reg=0x11; speed=10, link_up=1, speed_change pulse, mac_hold high 16 cycles.
REQ-038 Next response 16'h4400 (code 01): speed becomes 01, speed_change pulses, mac_hold high 16 cycles; repeated 16'h4400 causes no pulse and no hold.
REQ-039 Response 16'h0000 while link_up=1: link_up becomes 0, speed stays 01, hold 16 cycles; a second 16'h0000 causes no hold.
REQ-040 Response 16'hC400: code_err pulses once; speed, link_up and mac_hold unchanged.
REQ-041 Responder silent: timeout_err pulses exactly TIMEOUT_CYCLES after handshake; polling resumes; cmd_ready held low for 50 cycles keeps cmd_valid stable with fields unchanged.
REQ-042 rst_n pulsed low during WAIT_RSP: cmd_valid=0, speed=10, link_up=0 asynchronously; a late rsp_valid is ignored and no state changes.
